// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between instruction fetch and data access.
// Requests are latched into per-requester slots, one is granted, issued to the port with registered
// controls, and read data is returned to the owner after MEM_LATENCY cycles.
// Optional build macro MEM_ARB_RR_EN: round-robin tie-break (last-granted requester loses the next tie);
// without it data always wins over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              f_order,
  input  logic [31:0]       f_addr,
  output logic              f_accepted,
  output logic              f_done,
  output logic [31:0]       f_rdata,
  input  logic              d_order,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_accepted,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            st_q;
  logic              pf_q, pd_q, gd_q;
  logic [ADDR_W-1:0] fa_q, da_q;
  logic [3:0]        dwe_q;
  logic [31:0]       dw_q;
  logic [2:0]        cnt_q;
  logic              in_svc, cap_f, cap_d, pick_d, unused_bits;
  assign in_svc      = (st_q == ISSUE) || (st_q == WAIT);
  assign cap_f       = f_order && !pf_q && !(in_svc && !gd_q);
  assign cap_d       = d_order && !pd_q && !(in_svc && gd_q);
  assign busy        = (st_q != IDLE) || pf_q || pd_q;
  assign unused_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
`ifdef MEM_ARB_RR_EN
  logic last_d_q;
  assign pick_d = pd_q && (!pf_q || !last_d_q);
  // remember who was granted last so the other side wins the next tie
  always_ff @(posedge clk)
    if (!rstn) last_d_q <= 1'b0;
    else if (st_q == IDLE && (pf_q || pd_q)) last_d_q <= pick_d;
`else
  assign pick_d = pd_q;
`endif
  // request capture, grant, issue, wait for read data, done pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q <= IDLE;
      {pf_q, pd_q, gd_q, fa_q, da_q, dwe_q, dw_q, cnt_q} <= '0;
      {f_accepted, f_done, f_rdata, d_accepted, d_done, d_rdata} <= '0;
      {m_en, m_we, m_addr, m_wdata} <= '0;
    end else begin
      f_accepted <= cap_f;
      d_accepted <= cap_d;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      if (cap_f) begin
        pf_q <= 1'b1;
        fa_q <= f_addr[ADDR_W+1:2];
      end
      if (cap_d) begin
        pd_q  <= 1'b1;
        da_q  <= d_addr[ADDR_W+1:2];
        dwe_q <= d_we;
        dw_q  <= d_wdata;
      end
      case (st_q)
        IDLE: if (pf_q || pd_q) begin
          m_en    <= 1'b1;
          gd_q    <= pick_d;
          m_we    <= pick_d ? dwe_q : 4'd0;
          m_addr  <= pick_d ? da_q : fa_q;
          m_wdata <= pick_d ? dw_q : 32'd0;
          if (pick_d) pd_q <= 1'b0;
          else pf_q <= 1'b0;
          st_q <= ISSUE;
        end
        ISSUE: begin
          m_en  <= 1'b0;
          m_we  <= 4'd0;
          cnt_q <= 3'(MEM_LATENCY - 1);
          if (|m_we) begin
            d_done <= 1'b1;
            st_q   <= DONE;
          end else st_q <= WAIT;
        end
        WAIT: if (cnt_q == 3'd0) begin
          if (gd_q) d_rdata <= m_rdata;
          else f_rdata <= m_rdata;
          d_done <= gd_q;
          f_done <= !gd_q;
          st_q   <= DONE;
        end else cnt_q <= cnt_q - 3'd1;
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule
